// File: rtl/i2c_tx_arbiter_if.sv
// Command bus between the packet arbiter and a byte-level I2C master.
//   m_ready   : master idle/ready; drops low when it takes a command
//   m_start   : command is START followed by m_tx_data (address byte)
//   m_stop    : command is STOP
//   m_i2c_en  : command valid
//   m_tx_data : byte carried by the current command
// Modports: master = arbiter side (issues commands), slave = I2C master side.
interface i2c_tx_arbiter_if;
  logic       m_ready;
  logic       m_start;
  logic       m_stop;
  logic       m_i2c_en;
  logic [7:0] m_tx_data;

  modport master (
    input  m_ready,
    output m_start,
    output m_stop,
    output m_i2c_en,
    output m_tx_data
  );

  modport slave (
    output m_ready,
    input  m_start,
    input  m_stop,
    input  m_i2c_en,
    input  m_tx_data
  );
endinterface

// File: rtl/i2c_tx_arbiter.sv
// Shares one byte-level I2C master between two packet requesters.
// Round-robin arbitration, payload snapshot at grant, framing as
// START+address, LEN data bytes MSB-first, STOP. Supports abort and a
// per-command watchdog.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req0/req1         : level requests
//   len0/len1         : data byte counts (clamped to MAX_BYTES)
//   pay0/pay1         : payloads, byte k = pay[top-8k -: 8]
//   gnt0/gnt1         : high for the whole transaction of requester i
//   done0/done1       : 1-cycle pulse when packet i finishes
//   abort             : end current packet early with STOP
//   aborted           : pulse coincident with done for aborted packets
//   err_timeout       : pulse when the watchdog drops a transaction
//   busy              : high whenever the FSM is not idle
//   m                 : command bus to the I2C master (master modport)
module i2c_tx_arbiter #(
  parameter int         MAX_BYTES   = 5,
  parameter logic [7:0] SLV_ADDR    = 8'hAA,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [2:0]             len0,
  input  logic [2:0]             len1,
  input  logic [8*MAX_BYTES-1:0] pay0,
  input  logic [8*MAX_BYTES-1:0] pay1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   done0,
  output logic                   done1,
  input  logic                   abort,
  output logic                   aborted,
  output logic                   err_timeout,
  output logic                   busy,
  i2c_tx_arbiter_if.master       m
);

  localparam int PAY_W = 8 * MAX_BYTES;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_DATA  = 3'd2;
  localparam logic [2:0] CMD_STOP  = 3'd3;
  localparam logic [2:0] WAIT      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (int'(l) > MAX_BYTES) ? 3'(MAX_BYTES) : l;
  endfunction

  logic [2:0]      state_q, state_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            done0_q, done0_d, done1_q, done1_d;
  logic            aborted_q, aborted_d;
  logic            err_timeout_q, err_timeout_d;
  logic            m_start_q, m_start_d, m_stop_q, m_stop_d;
  logic            m_i2c_en_q, m_i2c_en_d;
  logic [7:0]      m_tx_data_q, m_tx_data_d;
  logic            last_grant_q, last_grant_d;
  logic [2:0]      len_q, len_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic            abort_pend_q, abort_pend_d;
  logic            stop_sent_q, stop_sent_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [PAY_W-1:0] pay_q, pay_d;

  logic            win;
  logic            active;
  logic [7:0]      cur_byte;

  // Byte selected by byte_idx, MSB-first within the snapshot.
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (byte_idx_q == 3'(k)) cur_byte = pay_q[PAY_W-1-8*k -: 8];
    end
  end

  assign active = (state_q == CMD_START) || (state_q == CMD_DATA) ||
                  (state_q == CMD_STOP)  || (state_q == WAIT);

  always_comb begin
    state_d       = state_q;
    gnt0_d        = gnt0_q;
    gnt1_d        = gnt1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    aborted_d     = 1'b0;
    err_timeout_d = 1'b0;
    m_start_d     = m_start_q;
    m_stop_d      = m_stop_q;
    m_i2c_en_d    = m_i2c_en_q;
    m_tx_data_d   = m_tx_data_q;
    last_grant_d  = last_grant_q;
    len_d         = len_q;
    byte_idx_d    = byte_idx_q;
    abort_pend_d  = abort_pend_q;
    stop_sent_d   = stop_sent_q;
    pay_d         = pay_q;
    win           = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          win          = (req0 && req1) ? ~last_grant_q : req1;
          gnt0_d       = ~win;
          gnt1_d       = win;
          len_d        = clamp_len(win ? len1 : len0);
          pay_d        = win ? pay1 : pay0;
          byte_idx_d   = '0;
          abort_pend_d = 1'b0;
          stop_sent_d  = 1'b0;
          m_start_d    = 1'b1;
          m_stop_d     = 1'b0;
          m_tx_data_d  = SLV_ADDR;
          // A busy master must go ready before the command is offered.
          m_i2c_en_d   = m.m_ready;
          state_d      = CMD_START;
        end
      end

      CMD_START, CMD_DATA, CMD_STOP: begin
        if (abort && state_q != CMD_STOP) abort_pend_d = 1'b1;
        if (!m_i2c_en_q) begin
          if (m.m_ready) m_i2c_en_d = 1'b1;
        end else if (!m.m_ready) begin
          // Master took the command.
          m_i2c_en_d  = 1'b0;
          m_start_d   = 1'b0;
          m_stop_d    = 1'b0;
          stop_sent_d = (state_q == CMD_STOP);
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (abort && !stop_sent_q) abort_pend_d = 1'b1;
        if (m.m_ready) begin
          if (stop_sent_q) begin
            done0_d   = gnt0_q;
            done1_d   = gnt1_q;
            aborted_d = abort_pend_q;
            state_d   = DONE;
          end else if (abort_pend_q || abort || byte_idx_q == len_q) begin
            m_stop_d   = 1'b1;
            m_i2c_en_d = 1'b1;
            state_d    = CMD_STOP;
          end else begin
            m_tx_data_d = cur_byte;
            byte_idx_d  = byte_idx_q + 3'd1;
            m_i2c_en_d  = 1'b1;
            state_d     = CMD_DATA;
          end
        end
      end

      DONE: begin
        last_grant_d = gnt1_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Watchdog drops the transaction without a STOP or done pulse.
    if (active && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      state_d       = IDLE;
      m_start_d     = 1'b0;
      m_stop_d      = 1'b0;
      m_i2c_en_d    = 1'b0;
      m_tx_data_d   = '0;
      gnt0_d        = 1'b0;
      gnt1_d        = 1'b0;
      done0_d       = 1'b0;
      done1_d       = 1'b0;
      aborted_d     = 1'b0;
      abort_pend_d  = 1'b0;
      err_timeout_d = 1'b1;
      last_grant_d  = gnt1_q;
    end

    if (!active || state_d != state_q) wd_d = '0;
    else                               wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      aborted_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      m_start_q     <= 1'b0;
      m_stop_q      <= 1'b0;
      m_i2c_en_q    <= 1'b0;
      m_tx_data_q   <= '0;
      last_grant_q  <= 1'b1;
      len_q         <= '0;
      byte_idx_q    <= '0;
      abort_pend_q  <= 1'b0;
      stop_sent_q   <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      aborted_q     <= aborted_d;
      err_timeout_q <= err_timeout_d;
      m_start_q     <= m_start_d;
      m_stop_q      <= m_stop_d;
      m_i2c_en_q    <= m_i2c_en_d;
      m_tx_data_q   <= m_tx_data_d;
      last_grant_q  <= last_grant_d;
      len_q         <= len_d;
      byte_idx_q    <= byte_idx_d;
      abort_pend_q  <= abort_pend_d;
      stop_sent_q   <= stop_sent_d;
      wd_q          <= wd_d;
    end
  end

  // Payload snapshot is pure data; it is only consumed after a grant loads it.
  always_ff @(posedge clk) begin
    pay_q <= pay_d;
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign aborted     = aborted_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != IDLE);
  assign m.m_start   = m_start_q;
  assign m.m_stop    = m_stop_q;
  assign m.m_i2c_en  = m_i2c_en_q;
  assign m.m_tx_data = m_tx_data_q;

endmodule
